// File: rtl/hsstl_phy_mac_rdata_proc_xn.sv
// HSST RX word to PIPE receive-side converter: per-lane error marking, SKP fix-up,
// lock tracking, error counting and CTC error flagging, all with one pclk of latency.
module hsstl_phy_mac_rdata_proc_xn #(
  parameter int LANES                = 4,
  parameter bit EN_CONTI_SKP_REPLACE = 1'b0,
  parameter int LOCK_CYCLES          = 8,
  parameter int UNLOCK_ERRS          = 4,
  parameter int ERR_CNT_W            = 16
) (
  input  logic                       pclk,
  input  logic                       rst_n,
  input  logic [47*LANES-1:0]        P_RDATA,
  input  logic                       rx_det_done,
  input  logic [LANES-1:0]           lx_rxdct_out_d,
  input  logic [LANES-1:0]           rx_elec_idle,
  input  logic                       cnt_clr,
  output logic [32*LANES-1:0]        phy_mac_rxdata,
  output logic [4*LANES-1:0]         phy_mac_rxdatak,
  output logic [3*LANES-1:0]         phy_mac_rxstatus,
  output logic [LANES-1:0]           phy_mac_rxvalid,
  output logic [ERR_CNT_W*LANES-1:0] err_cnt,
  output logic [LANES-1:0]           ctc_err_sticky
);

  localparam logic [7:0] LOCK_N   = 8'(LOCK_CYCLES);
  localparam logic [7:0] UNLOCK_N = 8'(UNLOCK_ERRS);
  localparam logic [7:0] K28_5    = 8'hBC;
  localparam logic [7:0] K28_0    = 8'h1C;
  localparam logic [7:0] K30_7    = 8'hFE;

  typedef enum logic [1:0] {UNLOCKED, ALIGN, LOCKED} state_t;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    logic [46:0]          word;
    logic [3:0][7:0]      bytes;
    logic [3:0]           kflag;
    logic [3:0]           dec_err;
    logic [3:0]           disp_err;
    logic [2:0]           code;
    logic                 err_cycle;
    logic                 has_com;
    logic                 skp_hit;
    logic [3:0][7:0]      data_nxt;
    logic [3:0]           datak_nxt;
    logic [2:0]           status_nxt;

    logic [3:0][7:0]      data_q;
    logic [3:0]           datak_q;
    logic [2:0]           status_q;
    logic                 valid_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 sticky_q;
    state_t               state;
    logic [7:0]           good_cnt;
    logic [7:0]           bad_cnt;

    assign word = P_RDATA[47*n +: 47];
    assign code = word[46:44];

    always_comb begin
      bytes    = '0;
      kflag    = '0;
      dec_err  = '0;
      disp_err = '0;
      has_com  = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bytes[i]    = word[11*i +: 8];
        disp_err[i] = word[11*i + 8];
        dec_err[i]  = word[11*i + 9];
        kflag[i]    = word[11*i + 10];
        if (bytes[i] == K28_5 && kflag[i])
          has_com = 1'b1;
      end
    end

    assign err_cycle = (|dec_err) | (|disp_err);

    // A clean COM/SKP/SKP/COM word is reordered so downstream sees SKP,COM in the upper half
    assign skp_hit = EN_CONTI_SKP_REPLACE && (code == 3'b011) && !err_cycle &&
                     (bytes == {K28_5, K28_0, K28_0, K28_5}) && (kflag == 4'hF);

    always_comb begin
      data_nxt  = bytes;
      datak_nxt = kflag;
      for (int i = 0; i < 4; i++) begin
        if (code[2:1] == 2'b11 || dec_err[i]) begin
          data_nxt[i]  = K30_7;
          datak_nxt[i] = 1'b1;
        end
      end
      if (skp_hit) begin
        data_nxt[3] = K28_0;
        data_nxt[2] = K28_5;
      end
    end

    always_comb begin
      if (rx_det_done)
        status_nxt = {1'b0, lx_rxdct_out_d[n], lx_rxdct_out_d[n]};
      else if (|dec_err)
        status_nxt = 3'b100;
      else if (code[2:1] == 2'b10)
        status_nxt = 3'b101;
      else if (code[2:1] == 2'b11)
        status_nxt = 3'b110;
      else if (|disp_err)
        status_nxt = 3'b111;
      else
        status_nxt = code;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        data_q   <= '0;
        datak_q  <= '0;
        status_q <= '0;
      end else begin
        data_q   <= data_nxt;
        datak_q  <= datak_nxt;
        status_q <= status_nxt;
      end
    end

    // valid_q is written alongside every state change so it tracks LOCKED with no extra lag
    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= UNLOCKED;
        good_cnt <= '0;
        bad_cnt  <= '0;
        valid_q  <= 1'b0;
      end else if (rx_elec_idle[n]) begin
        state    <= UNLOCKED;
        good_cnt <= '0;
        bad_cnt  <= '0;
        valid_q  <= 1'b0;
      end else begin
        case (state)
          UNLOCKED: begin
            if (!err_cycle && has_com) begin
              state    <= ALIGN;
              good_cnt <= 8'd1;
            end
          end
          ALIGN: begin
            if (err_cycle) begin
              state    <= UNLOCKED;
              good_cnt <= '0;
            end else if (good_cnt + 8'd1 == LOCK_N) begin
              state    <= LOCKED;
              good_cnt <= '0;
              bad_cnt  <= '0;
              valid_q  <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 8'd1;
            end
          end
          LOCKED: begin
            if (!err_cycle) begin
              bad_cnt <= '0;
            end else if (bad_cnt + 8'd1 == UNLOCK_N) begin
              state   <= UNLOCKED;
              bad_cnt <= '0;
              valid_q <= 1'b0;
            end else begin
              bad_cnt <= bad_cnt + 8'd1;
            end
          end
          default: begin
            state    <= UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            valid_q  <= 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        err_q    <= '0;
        sticky_q <= 1'b0;
      end else if (cnt_clr) begin
        err_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        if (err_cycle && err_q != {ERR_CNT_W{1'b1}})
          err_q <= err_q + 1'b1;
        if (code[2])
          sticky_q <= 1'b1;
      end
    end

    assign phy_mac_rxdata[32*n +: 32]              = data_q;
    assign phy_mac_rxdatak[4*n +: 4]               = datak_q;
    assign phy_mac_rxstatus[3*n +: 3]              = status_q;
    assign phy_mac_rxvalid[n]                      = valid_q;
    assign err_cnt[ERR_CNT_W*n +: ERR_CNT_W]       = err_q;
    assign ctc_err_sticky[n]                       = sticky_q;
  end

endmodule

// File: tb/tb_hsstl_phy_mac_rdata_proc_xn.sv
// Directed bench: dut0 has SKP replacement on and a 4-bit error counter,
// dut1 uses the defaults; both see the same stimulus.
module tb_hsstl_phy_mac_rdata_proc_xn;

  logic         pclk = 1'b0;
  logic         rst_n;
  logic [187:0] p_rdata;
  logic         rx_det_done;
  logic [3:0]   lx_rxdct_out_d;
  logic [3:0]   rx_elec_idle;
  logic         cnt_clr;
  logic [46:0]  lw [4];

  logic [127:0] d0_rxdata, d1_rxdata;
  logic [15:0]  d0_rxdatak, d1_rxdatak;
  logic [11:0]  d0_rxstatus, d1_rxstatus;
  logic [3:0]   d0_rxvalid, d1_rxvalid;
  logic [15:0]  d0_err_cnt;
  logic [63:0]  d1_err_cnt;
  logic [3:0]   d0_sticky, d1_sticky;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  assign p_rdata = {lw[3], lw[2], lw[1], lw[0]};

  hsstl_phy_mac_rdata_proc_xn #(
    .LANES(4), .EN_CONTI_SKP_REPLACE(1'b1), .LOCK_CYCLES(8),
    .UNLOCK_ERRS(4), .ERR_CNT_W(4)
  ) dut0 (
    .pclk(pclk), .rst_n(rst_n), .P_RDATA(p_rdata), .rx_det_done(rx_det_done),
    .lx_rxdct_out_d(lx_rxdct_out_d), .rx_elec_idle(rx_elec_idle), .cnt_clr(cnt_clr),
    .phy_mac_rxdata(d0_rxdata), .phy_mac_rxdatak(d0_rxdatak),
    .phy_mac_rxstatus(d0_rxstatus), .phy_mac_rxvalid(d0_rxvalid),
    .err_cnt(d0_err_cnt), .ctc_err_sticky(d0_sticky)
  );

  hsstl_phy_mac_rdata_proc_xn dut1 (
    .pclk(pclk), .rst_n(rst_n), .P_RDATA(p_rdata), .rx_det_done(rx_det_done),
    .lx_rxdct_out_d(lx_rxdct_out_d), .rx_elec_idle(rx_elec_idle), .cnt_clr(cnt_clr),
    .phy_mac_rxdata(d1_rxdata), .phy_mac_rxdatak(d1_rxdatak),
    .phy_mac_rxstatus(d1_rxstatus), .phy_mac_rxvalid(d1_rxvalid),
    .err_cnt(d1_err_cnt), .ctc_err_sticky(d1_sticky)
  );

  function automatic logic [46:0] mk_word(input logic [31:0] d, input logic [3:0] k,
                                          input logic [3:0] dec, input logic [3:0] disp,
                                          input logic [2:0] code);
    logic [46:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[11*i +: 8]  = d[8*i +: 8];
      w[11*i + 8]   = disp[i];
      w[11*i + 9]   = dec[i];
      w[11*i + 10]  = k[i];
    end
    w[46:44] = code;
    return w;
  endfunction

  task automatic apply_stimulus();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lock_lane0();
    lw[0] = mk_word(32'h000000BC, 4'b0001, 4'h0, 4'h0, 3'b000);
    apply_stimulus();
    lw[0] = '0;
    repeat (7) apply_stimulus();
  endtask

  initial begin
    rst_n          = 1'b0;
    rx_det_done    = 1'b0;
    lx_rxdct_out_d = '0;
    rx_elec_idle   = '0;
    cnt_clr        = 1'b0;
    for (int i = 0; i < 4; i++) lw[i] = '0;

    repeat (3) apply_stimulus();
    check_output("reset_rxdata", d0_rxdata[63:0], 64'h0);
    check_output("reset_rxvalid", d0_rxvalid, 4'h0);
    check_output("reset_err_cnt", d1_err_cnt, 64'h0);
    rst_n = 1'b1;

    $display("[TB] lock lane 0");
    lw[0] = mk_word(32'h000000BC, 4'b0001, 4'h0, 4'h0, 3'b000);
    apply_stimulus();
    check_output("com_data", d0_rxdata[31:0], 32'h000000BC);
    check_output("com_datak", d0_rxdatak[3:0], 4'b0001);
    check_output("com_valid", d0_rxvalid[0], 1'b0);
    lw[0] = '0;
    for (int c = 1; c <= 7; c++) begin
      apply_stimulus();
      if (c == 6) check_output("lock_edge7", d1_rxvalid[0], 1'b0);
      if (c == 7) check_output("lock_edge8", d1_rxvalid[0], 1'b1);
    end

    lw[0] = mk_word(32'h0, 4'h0, 4'h0, 4'b0001, 3'b000);
    repeat (3) apply_stimulus();
    check_output("disp3_valid", d0_rxvalid[0], 1'b1);
    check_output("disp3_status", d0_rxstatus[2:0], 3'b111);
    check_output("disp3_err_cnt", d1_err_cnt[15:0], 16'd3);
    lw[0] = '0;
    apply_stimulus();
    check_output("clean_after3_valid", d0_rxvalid[0], 1'b1);
    lw[0] = mk_word(32'h0, 4'h0, 4'h0, 4'b0001, 3'b000);
    repeat (2) apply_stimulus();
    check_output("err5_cnt", d0_err_cnt[3:0], 4'd5);
    check_output("err5_valid", d0_rxvalid[0], 1'b1);

    $display("[TB] reset mid-stream");
    rst_n = 1'b0;
    #2;
    check_output("midrst_valid", d0_rxvalid, 4'h0);
    check_output("midrst_err_cnt", d0_err_cnt, 16'h0);
    check_output("midrst_status", d0_rxstatus, 12'h0);
    rst_n = 1'b1;
    lw[0] = '0;

    lock_lane0();
    check_output("relock_valid", d1_rxvalid[0], 1'b1);
    lw[0] = mk_word(32'h0, 4'h0, 4'h0, 4'b0010, 3'b000);
    repeat (3) apply_stimulus();
    check_output("unlock_err3", d1_rxvalid[0], 1'b1);
    apply_stimulus();
    check_output("unlock_err4", d1_rxvalid[0], 1'b0);
    check_output("unlock_err_cnt", d1_err_cnt[15:0], 16'd4);

    $display("[TB] lane 1 decode error");
    lw[0] = '0;
    lw[1] = mk_word(32'h44332211, 4'h0, 4'b0100, 4'h0, 3'b000);
    apply_stimulus();
    check_output("dec_l1_data", d0_rxdata[63:32], 32'h44FE2211);
    check_output("dec_l1_datak", d0_rxdatak[7:4], 4'b0100);
    check_output("dec_l1_status", d0_rxstatus[5:3], 3'b100);
    check_output("dec_l1_err_cnt", d1_err_cnt[31:16], 16'd1);
    check_output("dec_l0_status", d0_rxstatus[2:0], 3'b000);
    check_output("dec_l0_err_cnt", d1_err_cnt[15:0], 16'd4);

    $display("[TB] SKP replacement");
    lw[1] = '0;
    lw[2] = mk_word(32'hBC1C1CBC, 4'hF, 4'h0, 4'h0, 3'b011);
    apply_stimulus();
    check_output("skp_on_data", d0_rxdata[95:64], 32'h1CBC1CBC);
    check_output("skp_on_datak", d0_rxdatak[11:8], 4'hF);
    check_output("skp_on_status", d0_rxstatus[8:6], 3'b011);
    check_output("skp_off_data", d1_rxdata[95:64], 32'hBC1C1CBC);
    check_output("skp_sticky", d0_sticky[2], 1'b0);

    $display("[TB] error counter saturation");
    lw[2] = '0;
    lw[3] = mk_word(32'h0, 4'h0, 4'b0001, 4'h0, 3'b000);
    repeat (20) apply_stimulus();
    check_output("sat_w4", d0_err_cnt[15:12], 4'hF);
    check_output("sat_w16", d1_err_cnt[63:48], 16'd20);
    cnt_clr = 1'b1;
    apply_stimulus();
    cnt_clr = 1'b0;
    check_output("clr_w4", d0_err_cnt[15:12], 4'h0);
    check_output("clr_w16", d1_err_cnt[63:48], 16'd0);

    $display("[TB] code 110");
    lw[3] = mk_word(32'h12345678, 4'h0, 4'h0, 4'h0, 3'b110);
    apply_stimulus();
    check_output("c110_data", d0_rxdata[127:96], 32'hFEFEFEFE);
    check_output("c110_datak", d0_rxdatak[15:12], 4'hF);
    check_output("c110_status", d0_rxstatus[11:9], 3'b110);
    check_output("c110_sticky", d0_sticky[3], 1'b1);
    lw[3] = '0;
    apply_stimulus();
    check_output("sticky_hold", d1_sticky[3], 1'b1);
    check_output("c110_no_err", d1_err_cnt[63:48], 16'd0);
    lw[3] = mk_word(32'h0, 4'h0, 4'h0, 4'h0, 3'b110);
    cnt_clr = 1'b1;
    apply_stimulus();
    cnt_clr = 1'b0;
    check_output("sticky_clr_prio", d1_sticky[3], 1'b0);
    lw[3] = '0;

    $display("[TB] receiver detect");
    rx_det_done    = 1'b1;
    lx_rxdct_out_d = 4'b0101;
    apply_stimulus();
    check_output("rxdet_status", d0_rxstatus, 12'b000_011_000_011);
    rx_det_done    = 1'b0;
    lx_rxdct_out_d = '0;

    $display("[TB] electrical idle");
    lock_lane0();
    check_output("idle_pre_valid", d0_rxvalid[0], 1'b1);
    rx_elec_idle = 4'b0001;
    apply_stimulus();
    rx_elec_idle = '0;
    check_output("idle_valid", d0_rxvalid[0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hsstl_phy_mac_rdata_proc_xn.md
HSSTL_PHY_MAC_RDATA_PROC_XN -- requirements
Module: hsstl_phy_mac_rdata_proc_xn

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent lanes (1..4).
REQ-002 SHALL have parameter EN_CONTI_SKP_REPLACE, default 1'b0, enables continuous-SKP-delete replacement.
REQ-003 SHALL have parameter LOCK_CYCLES, default 8, clean cycles required to declare lock (2..255).
REQ-004 SHALL have parameter UNLOCK_ERRS, default 4, consecutive error cycles that drop lock (1..255).
REQ-005 SHALL have parameter ERR_CNT_W, default 16, per-lane error counter width.
REQ-006 SHALL have ports, in this order:
- pclk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- P_RDATA  in  47*LANES  per-lane HSST RX word
- rx_det_done  in  1  receiver-detect result phase
- lx_rxdct_out_d  in  LANES  per-lane receiver-detect result
- rx_elec_idle  in  LANES  per-lane electrical idle
- cnt_clr  in  1  clears counters and sticky flags
- phy_mac_rxdata  out  32*LANES  data
- phy_mac_rxdatak  out  4*LANES  K flags
- phy_mac_rxstatus  out  3*LANES  PIPE RxStatus
- phy_mac_rxvalid  out  LANES  lane locked
- err_cnt  out  ERR_CNT_W*LANES  error-cycle count
- ctc_err_sticky  out  LANES  CTC over/underflow seen
REQ-007 SHALL use this lane-n word layout (base B=47n), byte i=0..3 at b=B+11i: [b+7:b] data, [b+8] disparity err, [b+9] decode err, [b+10] K; [B+46:B+44] status code.

Function
REQ-008 SHALL process every lane identically and independently; lane n output slices sit at 32n, 4n, 3n, ERR_CNT_W*n.
REQ-009 SHALL register data, datak and rxstatus with exactly one pclk latency.
REQ-010 SHALL set rxstatus, priority descending: rx_det_done -> {0, det, det}; any decode err -> 100; code 100/101 -> 101; code 110/111 -> 110; any disparity err -> 111; else code.
REQ-011 SHALL output byte i as K30.7 (8'hFE, K=1) when code is 110/111 or byte i decode err is set; else data/K pass through.
REQ-012 SHALL, when EN_CONTI_SKP_REPLACE=1, code=011, no decode/disparity err in any byte, and bytes 0..3 are K28.5, K28.0, K28.0, K28.5 (all K=1), output byte3=K28.0 (1C) and byte2=K28.5 (BC); bytes 0/1 pass; REQ-011 takes precedence.
REQ-013 SHALL define an error cycle as any byte having a decode or disparity error.
REQ-014 SHALL implement a per-lane FSM with states UNLOCKED, ALIGN, LOCKED:
- UNLOCKED -> ALIGN on a non-error cycle containing any byte equal to K28.5 with K=1; good count := 1.
- ALIGN: non-error cycle increments good count; on reaching LOCK_CYCLES -> LOCKED; error cycle -> UNLOCKED.
- LOCKED: error cycle increments bad count; non-error cycle clears it; on reaching UNLOCK_ERRS -> UNLOCKED.
- rx_elec_idle=1 forces UNLOCKED with both counts cleared, overriding all transitions.
REQ-015 SHALL drive phy_mac_rxvalid = (state==LOCKED), updated on the same edge as the data of the cycle causing the transition.
REQ-016 SHALL increment err_cnt on each error cycle, saturating at all-ones (no wrap).
REQ-017 SHALL set ctc_err_sticky when code is 100..111 and hold it until cnt_clr.
REQ-018 SHALL give cnt_clr priority over a same-cycle increment/set: result 0.
REQ-019 SHALL ignore rx_det_done for FSM, counters and data path.

Reset
REQ-020 SHALL, on rst_n low, asynchronously drive all outputs to 0 and all FSMs to UNLOCKED with counts 0; operation resumes on the first pclk after release.

Verification
REQ-021 Reset mid-stream with lane 0 LOCKED, err_cnt=5 -> all outputs 0 immediately, rxvalid 0, err_cnt 0.
REQ-022 Lane 1 byte 2 decode err -> next edge lane1 rxdata[23:16]=FE, datak[2]=1, rxstatus=100, err_cnt+1; other lanes unaffected.
REQ-023 Clean K28.5 cycle then 7 clean cycles (LOCK_CYCLES=8) -> rxvalid rises on 8th edge; 4 consecutive disparity-error cycles -> rxvalid falls on 4th; 3 errors then clean -> stays 1.
REQ-024 EN_CONTI_SKP_REPLACE=1, code 011, bytes BC/1C/1C/BC K=1111 -> out 32'h BC1C1CBC become 32'h1CBC1CBC, status 011; with parameter 0 -> unchanged.
REQ-025 ERR_CNT_W=4, 20 error cycles -> err_cnt holds 15; cnt_clr coinciding with error cycle -> 0; code 110 -> all bytes FE/K, status 110, sticky 1.
REQ-026 rx_det_done=1, lx_rxdct_out_d=4'b0101 -> rxstatus lanes 0,2=011, lanes 1,3=000; rx_elec_idle pulse on LOCKED lane -> rxvalid 0 next edge.
